// File: rtl/encoder_pkg.sv
// Shared widths and FSM encoding for the encoder transmit-side arbiter.
package encoder_pkg;

    localparam int AXIS_DATA_W = 32;
    localparam int AXIS_STRB_W = 4;
    localparam int ACTIVE_W    = 3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/encoder_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after the last grant.
module rr_arbiter
    import encoder_pkg::*;
#(
    parameter int NUM_SRC = 2
) (
    input  logic [NUM_SRC-1:0]  i_req,
    input  logic [ACTIVE_W-1:0] i_last_grant,
    output logic [ACTIVE_W-1:0] o_grant,
    output logic                o_valid
);

    localparam int SEL_W = $clog2(NUM_SRC);

    // Scan from last_grant+1 around the ring; the first hit wins.
    always_comb begin
        int   idx;
        logic hit;
        idx     = 0;
        hit     = 1'b0;
        o_grant = '0;
        o_valid = 1'b0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx     = (int'(i_last_grant) + k) % NUM_SRC;
            hit     = !o_valid && i_req[SEL_W'(idx)];
            o_grant = hit ? ACTIVE_W'(idx) : o_grant;
            o_valid = o_valid | hit;
        end
    end

endmodule

// File: rtl/encoder_tx_arbiter.sv
// Packet-granular round-robin merge of NUM_SRC AXI-Stream sources onto the encoder input.
module encoder_tx_arbiter
    import encoder_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 16
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [NUM_SRC*32-1:0]        s_axis_tdata,
    input  logic [NUM_SRC*4-1:0]         s_axis_tstrb,
    input  logic [NUM_SRC-1:0]           s_axis_tlast,
    input  logic [NUM_SRC-1:0]           s_axis_tvalid,
    output logic [NUM_SRC-1:0]           s_axis_tready,
    input  logic [NUM_SRC-1:0]           src_encap,
    output logic [AXIS_DATA_W-1:0]       m_axis_tdata,
    output logic [AXIS_STRB_W-1:0]       m_axis_tstrb,
    output logic                         m_axis_tlast,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         encapsulated,
    output logic [ACTIVE_W-1:0]          active_src,
    output logic                         busy,
    output logic                         pkt_done,
    output logic [NUM_SRC*CNT_W-1:0]     pkt_count
);

    localparam int SEL_W = $clog2(NUM_SRC);

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [ACTIVE_W-1:0]     r_active_src;
    logic [ACTIVE_W-1:0]     r_last_grant;
    logic                    r_encap;
    logic                    r_pkt_done;
    logic [CNT_W-1:0]        r_pkt_count [NUM_SRC];
    logic [ACTIVE_W-1:0]     w_arb_grant;
    logic                    w_arb_valid;
    logic [SEL_W-1:0]        w_sel;
    logic                    w_sel_last;
    logic                    w_accept;
    logic [AXIS_DATA_W-1:0]  w_src_data [NUM_SRC];
    logic [AXIS_STRB_W-1:0]  w_src_strb [NUM_SRC];

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign w_src_data[g] = s_axis_tdata[g*AXIS_DATA_W +: AXIS_DATA_W];
        assign w_src_strb[g] = s_axis_tstrb[g*AXIS_STRB_W +: AXIS_STRB_W];
        assign pkt_count[g*CNT_W +: CNT_W] = r_pkt_count[g];
    end

    rr_arbiter #(.NUM_SRC(NUM_SRC)) u_rr (
        .i_req        (s_axis_tvalid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_arb_grant),
        .o_valid      (w_arb_valid)
    );

    assign w_sel        = r_active_src[SEL_W-1:0];
    assign w_sel_last   = s_axis_tlast[w_sel];
    assign w_accept     = m_axis_tvalid && m_axis_tready;
    assign busy         = (r_state == ST_BUSY);
    assign active_src   = r_active_src;
    assign encapsulated = r_encap;
    assign pkt_done     = r_pkt_done;

    // FSM state register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: grant is held from first beat until the accepted tlast
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_valid) w_state_nxt = ST_BUSY;
                else             w_state_nxt = ST_IDLE;
            end
            ST_BUSY: begin
                if (w_accept && w_sel_last) w_state_nxt = ST_IDLE;
                else                        w_state_nxt = ST_BUSY;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: zero-latency data mux from the registered owner
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tstrb  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tvalid = 1'b0;
        s_axis_tready = '0;
        if (r_state == ST_BUSY) begin
            m_axis_tdata         = w_src_data[w_sel];
            m_axis_tstrb         = w_src_strb[w_sel];
            m_axis_tlast         = w_sel_last;
            m_axis_tvalid        = s_axis_tvalid[w_sel];
            s_axis_tready[w_sel] = m_axis_tready;
        end else begin
            s_axis_tready = '0;
        end
    end

    // Grant, encap latch, completion pulse and per-source packet counters
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_active_src <= '0;
            r_last_grant <= ACTIVE_W'(NUM_SRC - 1);
            r_encap      <= 1'b0;
            r_pkt_done   <= 1'b0;
            for (int i = 0; i < NUM_SRC; i++) r_pkt_count[i] <= '0;
        end else begin
            r_pkt_done <= 1'b0;
            if (r_state == ST_IDLE && w_arb_valid) begin
                r_active_src <= w_arb_grant;
                r_last_grant <= w_arb_grant;
                r_encap      <= src_encap[w_arb_grant[SEL_W-1:0]];
            end else if (r_state == ST_BUSY && w_accept && w_sel_last) begin
                r_pkt_done           <= 1'b1;
                r_pkt_count[w_sel]   <= r_pkt_count[w_sel] + CNT_W'(1);
                r_active_src         <= '0;
            end else begin
                r_active_src <= r_active_src;
            end
        end
    end

endmodule
